// File: rtl/in_port_ctrl.sv
// Input-device side of the `in` handshake: synchronizes the switches, debounces the enter
// button and sequences a clean enter level (low -> high -> low) with the captured switch word.
module in_port_ctrl #(
  parameter int unsigned SW_W       = 18,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned DEB_CYCLES = 500000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              btn_raw,
  input  logic [SW_W-1:0]   sw_raw,
  input  logic              in_req,
  output logic              enter,
  output logic [DATA_W-1:0] data_out,
  output logic              waiting
);

  localparam int unsigned CNT_W = $clog2(DEB_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEB_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE,
    ARMED,
    PRESSED,
    RELEASED
  } state_t;

  logic              btn_s1_q, btn_s2_q;
  logic [SW_W-1:0]   sw_s1_q, sw_s2_q;
  logic              btn_clean_q, btn_clean_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  state_t            state_q, state_d;
  logic              enter_q, enter_d;
  logic              waiting_q, waiting_d;
  logic [DATA_W-1:0] data_q, data_d;

  // Debounce: the synchronized level must differ from the clean level for DEB_CYCLES
  // consecutive cycles before the clean level follows it.
  always_comb begin
    btn_clean_d = btn_clean_q;
    cnt_d       = '0;
    if (btn_s2_q != btn_clean_q) begin
      if (cnt_q == CNT_MAX) begin
        btn_clean_d = ~btn_clean_q;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:     if (in_req && !btn_clean_q) state_d = ARMED;
      ARMED:    if (!in_req) state_d = IDLE;
                else if (btn_clean_q) state_d = PRESSED;
      PRESSED:  if (!in_req) state_d = IDLE;
                else if (!btn_clean_q) state_d = RELEASED;
      RELEASED: if (!in_req) state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  // Outputs are decoded from the next state so they change on the same edge as the state.
  always_comb begin
    enter_d   = (state_d == PRESSED);
    waiting_d = (state_d == ARMED);
    data_d    = data_q;
    if (state_q == ARMED && state_d == PRESSED) begin
      data_d = DATA_W'(sw_s2_q);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      btn_s1_q    <= 1'b0;
      btn_s2_q    <= 1'b0;
      sw_s1_q     <= '0;
      sw_s2_q     <= '0;
      btn_clean_q <= 1'b0;
      cnt_q       <= '0;
      state_q     <= IDLE;
      enter_q     <= 1'b0;
      waiting_q   <= 1'b0;
      data_q      <= '0;
    end else begin
      btn_s1_q    <= btn_raw;
      btn_s2_q    <= btn_s1_q;
      sw_s1_q     <= sw_raw;
      sw_s2_q     <= sw_s1_q;
      btn_clean_q <= btn_clean_d;
      cnt_q       <= cnt_d;
      state_q     <= state_d;
      enter_q     <= enter_d;
      waiting_q   <= waiting_d;
      data_q      <= data_d;
    end
  end

  assign enter    = enter_q;
  assign waiting  = waiting_q;
  assign data_out = data_q;

endmodule
